fifo_stream_out: RTL and testbench

//  Downstream drain stage for the fifo block: issues fifo read strobes, absorbs
//  the fifo read latency in a small skid buffer, and presents entries as a

---
 rtl/fifo_stream_out.sv | 171 +++++++++++++++++
 tb/tb_fifo_stream_out.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// rtl/fifo_stream_out.sv - fifo drain stage: read issue, latency skid buffer, valid/ready output stream
// Optional feature macro: FIFO_STREAM_OUT_STATS_EN (adds beat_count / stall_count outputs).
module fifo_stream_out #(
  parameter  int WIDTH  = 8,
  parameter  int SIZE   = 12,
  parameter  int RD_LAT = 1,
  localparam int DEPTH  = RD_LAT + 1,
  localparam int LW     = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_write,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LW-1:0]    level,
  output logic             overflow
`ifdef FIFO_STREAM_OUT_STATS_EN
  ,
  output logic [15:0]      beat_count,
  output logic [15:0]      stall_count
`endif
);

  // Pointer width for the skid ring; count width covers skid + in-flight (at most 2*DEPTH-1 <= 7).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = 4;

  // Mirrored fifo occupancy and sticky overflow.
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;

  // One bit per outstanding fifo read; the top bit marks data arriving this cycle.
  logic [RD_LAT-1:0] track_q, track_d;

  // Skid buffer: circular storage with separate write/read pointers and a fill count.
  logic [WIDTH-1:0] skid_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    skid_cnt_q, skid_cnt_d;

  logic [CW-1:0]    inflight;
  logic [CW-1:0]    credit_use;
  logic             pop;
  logic             push;

`ifdef FIFO_STREAM_OUT_STATS_EN
  logic [15:0]      beat_count_q, beat_count_d;
  logic [15:0]      stall_count_q, stall_count_d;
`endif

  assign pop      = m_valid & m_ready;
  assign push     = track_q[RD_LAT-1];
  assign m_valid  = (skid_cnt_q != '0);
  assign m_data   = skid_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

  // Count reads still travelling through the fifo read pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(track_q[i]);
    end
  end

  // Issue a read only when the fifo holds data and a skid slot is guaranteed for its return.
  // A pop this cycle frees a slot immediately, giving a combinational m_ready -> fifo_read path.
  always_comb begin
    credit_use = skid_cnt_q + inflight - CW'(pop);
    fifo_read  = !rst && (level_q != '0) && (credit_use < CW'(DEPTH));
  end

  // Next-state for occupancy mirror, overflow flag and return tracking.
  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q;
    track_d    = track_q << 1;
    track_d[0] = fifo_read;
    case ({fifo_write, fifo_read})
      2'b10: begin
        if (level_q == LW'(SIZE)) begin
          overflow_d = 1'b1;
        end else begin
          level_d = level_q + LW'(1);
        end
      end
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state for the skid ring pointers and fill count.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    skid_cnt_d = skid_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + CW'(1);
      2'b01:   skid_cnt_d = skid_cnt_q - CW'(1);
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // Register control state; reset drops any in-flight returns so nothing stale is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
      track_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
      track_q    <= track_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Capture returning fifo data at the skid tail; cleared on reset so m_data reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        skid_q[i] <= '0;
      end
    end else if (push) begin
      skid_q[wr_ptr_q] <= fifo_read_data;
    end
  end

`ifdef FIFO_STREAM_OUT_STATS_EN
  // Beat and stall counters wrap naturally at 16 bits.
  always_comb begin
    beat_count_d  = beat_count_q;
    stall_count_d = stall_count_q;
    if (pop) begin
      beat_count_d = beat_count_q + 16'd1;
    end
    if (m_valid && !m_ready) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Register the statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// tb/tb_fifo_stream_out.sv - directed self-checking bench for fifo_stream_out with a behavioural fifo
module tb_fifo_stream_out;

  logic       clk;
  logic       rst;
  logic       fifo_write;
  logic       fifo_read;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] level;
  logic       overflow;
`ifdef FIFO_STREAM_OUT_STATS_EN
  logic [15:0] beat_count;
  logic [15:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fifo_stream_out #(.WIDTH(8), .SIZE(12), .RD_LAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_write     (fifo_write),
    .fifo_read      (fifo_read),
    .fifo_read_data (rdata),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .level          (level),
    .overflow       (overflow)
`ifdef FIFO_STREAM_OUT_STATS_EN
    ,
    .beat_count     (beat_count),
    .stall_count    (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 12-deep fifo with one cycle read latency; drops writes when full.
  logic [7:0] fq[$];
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      rdata <= 8'h00;
    end else begin
      if (fifo_read && fq.size() > 0) rdata <= fq.pop_front();
      if (fifo_write && fq.size() < 12) fq.push_back(wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_write = 1'b0; m_ready = 1'b0; wdata = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic fill14();
    m_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      fifo_write = 1'b1;
      wdata = 8'h55 + 8'(i);
      step();
    end
    fifo_write = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_write = 1'b0; m_ready = 1'b0; wdata = 8'h00;
    @(negedge clk);
    n_tests++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_read got %b exp 0", fifo_read); end
    n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_m_data got %h exp 00", m_data); end
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL idle_m_valid got %b exp 0", m_valid); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL idle_level got %0d exp 0", level); end
    n_tests++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL idle_fifo_read got %b exp 0", fifo_read); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow got %b exp 0", overflow); end
    step();
  endtask

  task automatic test_single();
    logic [5:0] exp_rd;
    logic [5:0] exp_v;
    exp_rd = 6'b000010;
    exp_v  = 6'b001000;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      fifo_write = (c == 0);
      wdata = 8'h54;
      m_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (fifo_read !== exp_rd[c]) begin n_fail++; $display("FAIL single_fifo_read c%0d got %b exp %b", c, fifo_read, exp_rd[c]); end
      n_tests++; if (m_valid !== exp_v[c]) begin n_fail++; $display("FAIL single_m_valid c%0d got %b exp %b", c, m_valid, exp_v[c]); end
      if (c == 3) begin
        n_tests++; if (m_data !== 8'h54) begin n_fail++; $display("FAIL single_m_data got %h exp 54", m_data); end
      end
      if (c >= 2) begin
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level c%0d got %0d exp 0", c, level); end
      end
      step();
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    fill14();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (level !== 4'd12) begin n_fail++; $display("FAIL fill_level got %0d exp 12", level); end
      n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL fill_m_valid got %b exp 1", m_valid); end
      n_tests++; if (m_data !== 8'h55) begin n_fail++; $display("FAIL fill_m_data_hold got %h exp 55", m_data); end
      n_tests++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL fill_no_read got %b exp 0", fifo_read); end
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== 8'h55 + 8'(i)) begin
        n_fail++;
        $display("FAIL drain_beat%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 8'h55 + 8'(i));
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_m_valid got %b exp 0", m_valid); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL drain_end_level got %0d exp 0", level); end
`ifdef FIFO_STREAM_OUT_STATS_EN
    n_tests++; if (beat_count !== 16'd14) begin n_fail++; $display("FAIL stats_beat_count got %0d exp 14", beat_count); end
    n_tests++; if (stall_count !== 16'd16) begin n_fail++; $display("FAIL stats_stall_count got %0d exp 16", stall_count); end
`endif
    m_ready = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    fill14();
    fifo_write = 1'b1; wdata = 8'h99;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b exp 0", overflow); end
    step();
    fifo_write = 1'b0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
    n_tests++; if (level !== 4'd12) begin n_fail++; $display("FAIL ovf_level got %0d exp 12", level); end
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== 8'h55 + 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain_beat%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 8'h55 + 8'(i));
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL ovf_drained_level got %0d exp 0", level); end
    step();
    rst = 1'b1; m_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %b exp 0", overflow); end
    step();
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_seq [8];
    int idx;
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'h10 + 8'(i);
    exp_seq[7] = 8'h20;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fifo_write = 1'b1; wdata = 8'h10 + 8'(i);
      step();
    end
    fifo_write = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL simul_pre_level got %0d exp 5", level); end
    step();
    fifo_write = 1'b1; wdata = 8'h20; m_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL simul_fifo_read got %b exp 1", fifo_read); end
    n_tests++; if (m_data !== 8'h10) begin n_fail++; $display("FAIL simul_head got %h exp 10", m_data); end
    step();
    fifo_write = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL simul_level got %0d exp 5", level); end
    step();
    m_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid && idx < 8) begin
        n_tests++;
        if (m_data !== exp_seq[idx]) begin
          n_fail++;
          $display("FAIL simul_order beat%0d got %h exp %h", idx, m_data, exp_seq[idx]);
        end
        idx++;
      end
      step();
    end
    n_tests++; if (idx !== 8) begin n_fail++; $display("FAIL simul_beats got %0d exp 8", idx); end
    n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL simul_end_level got %0d exp 0", level); end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    fifo_write = 1'b1; wdata = 8'h77;
    step();
    fifo_write = 1'b0;
    @(negedge clk);
    n_tests++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL midrst_read got %b exp 1", fifo_read); end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL midrst_read_in_rst got %b exp 0", fifo_read); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid c%0d got %b exp 0", c, m_valid); end
      n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL midrst_level c%0d got %0d exp 0", c, level); end
      step();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fifo_write = 1'b0; m_ready = 1'b0; wdata = 8'h00;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
